// File: rtl/switch_cond_pkg.sv
// Shared types and defaults for the switch conditioning front end.
package switch_cond_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous board input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/switch_control_conditioner.sv
// Synchronizes and debounces a raw switch into a clean control level
// with one-cycle press/release pulses and an optional toggle mode.
module switch_control_conditioner
  import switch_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit TOGGLE_MODE     = 1'b0,
  parameter bit CONTROL_RESET   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic control,
  output logic press_pulse,
  output logic release_pulse,
  output logic settling
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic CTL_RST = TOGGLE_MODE ? CONTROL_RESET : 1'b0;

  logic          sync;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          control_q, control_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sw_in),
    .q_o (sync)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    control_d = control_q;
    unique case (state_q)
      S_LOW: begin
        if (sync) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    // Level mode tracks the debounced level of the next state.
    if (TOGGLE_MODE) begin
      control_d = control_q ^ press_d;
    end else begin
      control_d = (state_d == S_HIGH) | (state_d == S_WAIT_LOW);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      control_q <= CTL_RST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      control_q <= control_d;
    end
  end

  assign control       = control_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign settling      = (state_q == S_WAIT_HIGH) |
                         (state_q == S_WAIT_LOW);

endmodule

// File: tb/tb_switch_control_conditioner.sv
// Directed bench: level-mode and toggle-mode instances share one stimulus.
module tb_switch_control_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw  = 1'b0;

  logic l_ctl, l_pr, l_rl, l_st;
  logic t_ctl, t_pr, t_rl, t_st;

  int n_cmp = 0;
  int n_bad = 0;

  always #2 clk = ~clk;

  switch_control_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .TOGGLE_MODE     (1'b0),
    .CONTROL_RESET   (1'b1)
  ) u_lvl (
    .clk           (clk),
    .rst           (rst),
    .sw_in         (sw),
    .control       (l_ctl),
    .press_pulse   (l_pr),
    .release_pulse (l_rl),
    .settling      (l_st)
  );

  switch_control_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .TOGGLE_MODE     (1'b1),
    .CONTROL_RESET   (1'b1)
  ) u_tgl (
    .clk           (clk),
    .rst           (rst),
    .sw_in         (sw),
    .control       (t_ctl),
    .press_pulse   (t_pr),
    .release_pulse (t_rl),
    .settling      (t_st)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Toggle instance shares pulses/settling with level instance.
  task automatic expect_out(input string tag, input logic c,
                            input logic p, input logic r,
                            input logic s, input logic tc);
    check(tag,
          {l_ctl, l_pr, l_rl, l_st, t_ctl, t_pr, t_rl, t_st},
          {c, p, r, s, tc, p, r, s});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] pat;
    pat = 12'b0000_0001_1011;

    rst = 1'b1;
    sw  = 1'b0;
    repeat (3) tick();
    expect_out("reset", 0, 0, 0, 0, 1);
    rst = 1'b0;

    for (int k = 0; k < 20; k++) begin
      tick();
      expect_out($sformatf("idle%0d", k), 0, 0, 0, 0, 1);
    end

    sw = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_out($sformatf("press1_e%0d", k),
                 k >= 6, k == 6, 0, (k >= 2) && (k < 6), k < 6);
    end

    sw = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_out($sformatf("rel1_e%0d", k),
                 k < 6, 0, k == 6, (k >= 2) && (k < 6), 0);
    end

    for (int k = 0; k < 12; k++) begin
      sw = pat[k];
      tick();
      expect_out($sformatf("bounce_e%0d", k), 0, 0, 0,
                 (k == 2) || (k == 3) || (k == 5) || (k == 6), 0);
    end

    sw = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_out($sformatf("press2_e%0d", k),
                 k >= 6, k == 6, 0, (k >= 2) && (k < 6), k >= 6);
    end

    sw = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_out($sformatf("rel2_e%0d", k),
                 k < 6, 0, k == 6, (k >= 2) && (k < 6), 1);
    end

    sw = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_out($sformatf("midq_e%0d", k), 0, 0, 0, k >= 2, 1);
    end
    rst = 1'b1;
    #1;
    expect_out("rst_async", 0, 0, 0, 0, 1);
    tick();
    expect_out("rst_held", 0, 0, 0, 0, 1);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      expect_out($sformatf("post_rst_e%0d", k),
                 k >= 6, k == 6, 0, (k >= 2) && (k < 6), k < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
